clk_div_multi: RTL and testbench
================================

// Module: clk_div_multi
// PURPOSE
//   Multi-channel programmable clock divider / clock-enable generator for the FPGA pipeline-CPU top.
//   Each channel derives a divided square wave plus a 1-cycle tick strobe from in_clk.
//   Divisor and mode are runtime-configurable through a valid/ready port, applied glitch-free.
//   A STEP mode produces exactly one output period per request, for single-stepping the CPU.
// PARAMETERS
//   CH          2    number of independent divider channels (>=1)
//   CW          16   divisor / counter width in bits
//   DEFAULT_DIV 20   divisor loaded into every channel at reset (>=2)
// PORTS
//   in_clk     in   1              system clock; all logic on posedge
//   rst_n      in   1              synchronous reset, active low
//   cfg_valid  in   1              config request
//   cfg_ready  out  1              config accepted when cfg_valid && cfg_ready
//   cfg_ch     in   max(1,$clog2(CH))  target channel; values >= CH are accepted and dropped
//   cfg_div    in   CW             new divisor (output period in in_clk cycles)
//   cfg_mode   in   2              00 OFF, 01 RUN, 10 STEP, 11 treated as OFF
//   step_req   in   CH             per-channel single-step request (level sampled each cycle)
//   out_clk    out  CH             divided clock per channel (registered)
//   out_tick   out  CH             1-cycle pulse, high in the cycle out_clk goes 0->1
//   step_busy  out  CH             STEP-mode period in progress
// BEHAVIOUR
//   Reset: clock and reset port names and behaviour: one clock; reset is synchronous and active-low.
//   Reset state (rst_n low at posedge): cnt=0, div=DEFAULT_DIV, mode=RUN, out_clk=0, out_tick=0,
//     step_busy=0, pending=0, cfg_ready=1.
//   Divisor clamp: effective div = max(cfg_div,2); half = div>>1.
//   Per-channel counter cnt, 0..div-1, advances every cycle while active (RUN, or STEP with step_busy=1).
//     - cnt==div-1: cnt<=0, out_clk<=1, out_tick<=1 (wrap = period boundary).
//     - cnt==half-1: out_clk<=0. Otherwise out_clk holds; out_tick=0 except on wrap.
//     - High phase = half cycles, low phase = div-half cycles (20 -> 10/10, 3 -> 1/2).
//   After reset the first out_clk rise is at the div-th posedge with rst_n high (cnt starts 0, out_clk 0).
//   OFF: cnt held 0, out_clk=0, out_tick=0, step_busy=0.
//   STEP: idle with out_clk=0; step_req=1 while step_busy=0 -> step_busy<=1, cnt runs from 0.
//     - Period ends at wrap: step_busy<=0, cnt<=0, out_clk stays 0 (no rise, no tick on the end wrap).
//     - Rising edge of stepped period: out_clk<=1, out_tick<=1 on the cycle step is accepted.
//     - step_req while step_busy=1 is ignored (not queued); held step_req restarts next idle cycle.
//   Config handshake: cfg_ready = ~pending[cfg_ch] (1 when cfg_ch >= CH).
//     - Accept latches {div,mode} into the channel's shadow register, sets pending.
//     - Apply point: RUN -> at next wrap; STEP -> immediately if step_busy=0, else at period end;
//       OFF -> next cycle. On apply: pending<=0, cnt<=0, out_clk per new mode's wrap rule.
//     - Mode change to OFF applies at the boundary like any other, so no runt pulse is emitted.
//   Simultaneous events: accept on a channel in the same cycle its pending clears is impossible
//     (cfg_ready was low); step_req in the same cycle a config applies uses the new config.
//   Reset mid-operation: all state returns to reset values on the next posedge, pending config lost.
//   Channels are fully independent; no shared counter.
// TESTING
//   1 Reset, RUN default: rst_n high 100 cycles -> ch0 out_clk rises at cycle 20, 40, 60; 10 high/10 low; tick 1 cycle each.
//   2 Reprogram mid-period: cfg ch1 div=6 at cycle 25 -> cfg_ready low until ch1 wrap at 40; then period 6 (3/3).
//   3 Odd/clamp: div=3 -> 1 high/2 low; div=0 and div=1 -> behave as div=2 (1/1).
//   4 STEP: cfg ch0 mode=STEP div=4; step_req pulse -> one high 2/low 2 period, one tick, step_busy 4 cycles; 2nd req during busy ignored.
//   5 OFF: cfg mode=OFF while RUN -> out_clk finishes current period, then stays 0, tick never asserts.
//   6 Reset mid-op: rst_n low for 1 cycle during pending cfg -> div=20, RUN, pending cleared, cfg_ready=1.

Source files
------------

// File: rtl/clk_div_multi_if.sv
// Config port for clk_div_multi: one valid/ready request
// carrying target channel, divisor and mode.
interface clk_div_multi_if #(
  parameter int CH = 2,
  parameter int CW = 16
);
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

  logic           cfg_valid;
  logic           cfg_ready;
  logic [CHW-1:0] cfg_ch;
  logic [CW-1:0]  cfg_div;
  logic [1:0]     cfg_mode;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_div,
    output cfg_mode,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_div,
    input  cfg_mode,
    output cfg_ready
  );
endinterface

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with tick strobes,
// boundary-applied reconfiguration and single-step mode.
module clk_div_multi #(
  parameter int CH          = 2,
  parameter int CW          = 16,
  parameter int DEFAULT_DIV = 20
) (
  input  logic          in_clk,
  input  logic          rst_n,
  clk_div_multi_if.slave cfg,
  input  logic [CH-1:0] step_req,
  output logic [CH-1:0] out_clk,
  output logic [CH-1:0] out_tick,
  output logic [CH-1:0] step_busy
);
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
  localparam int NCH = 1 << CHW;

  typedef enum logic [1:0] {
    M_OFF  = 2'b00,
    M_RUN  = 2'b01,
    M_STEP = 2'b10
  } mode_t;

  logic [CH-1:0]  w_pend_v;
  logic [NCH-1:0] w_pend_x;
  logic [CW-1:0]  w_sdiv_in;
  mode_t          w_smode_in;

  // Unpopulated channel numbers read as never pending, so they
  // are accepted and silently dropped.
  always_comb begin
    w_pend_x = '0;
    w_pend_x[CH-1:0] = w_pend_v;
  end

  assign cfg.cfg_ready = ~w_pend_x[cfg.cfg_ch];
  assign w_sdiv_in = (cfg.cfg_div < CW'(2)) ? CW'(2)
                                            : cfg.cfg_div;
  assign w_smode_in = (cfg.cfg_mode == 2'b11) ? M_OFF
                                              : mode_t'(cfg.cfg_mode);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [CW-1:0] r_cnt, r_div, r_sdiv;
    logic [CW-1:0] w_cnt, w_div, w_sdiv, w_half;
    mode_t         r_mode, r_smode, w_mode, w_smode;
    logic          r_clk, r_tick, r_busy, r_pend;
    logic          w_clk, w_tick, w_busy, w_pend;
    logic          w_acc, w_wrap, w_hpt, w_apply;

    assign w_acc  = cfg.cfg_valid && cfg.cfg_ready
                 && (cfg.cfg_ch == CHW'(i));
    assign w_half = r_div >> 1;
    assign w_wrap = (r_cnt == r_div - CW'(1));
    assign w_hpt  = (r_cnt == w_half - CW'(1));

    // Shadow config only lands on a period boundary (or at once
    // when the channel is idle), which keeps the output glitch-free.
    always_comb begin
      w_apply = 1'b0;
      if (r_pend) begin
        unique case (r_mode)
          M_RUN:   w_apply = w_wrap;
          M_STEP:  w_apply = !r_busy || w_wrap;
          default: w_apply = 1'b1;
        endcase
      end
    end

    always_comb begin
      w_cnt   = r_cnt;
      w_div   = r_div;
      w_mode  = r_mode;
      w_clk   = r_clk;
      w_tick  = 1'b0;
      w_busy  = r_busy;
      w_pend  = r_pend;
      w_sdiv  = r_sdiv;
      w_smode = r_smode;
      if (w_apply) begin
        w_div  = r_sdiv;
        w_mode = r_smode;
        w_pend = 1'b0;
        w_cnt  = '0;
        w_busy = 1'b0;
        w_clk  = 1'b0;
        unique case (r_smode)
          M_RUN: begin
            w_clk  = 1'b1;
            w_tick = 1'b1;
          end
          M_STEP: begin
            if (step_req[i] && !r_busy) begin
              w_busy = 1'b1;
              w_clk  = 1'b1;
              w_tick = 1'b1;
            end
          end
          default: ;
        endcase
      end else begin
        unique case (r_mode)
          M_RUN: begin
            if (w_wrap) begin
              w_cnt  = '0;
              w_clk  = 1'b1;
              w_tick = 1'b1;
            end else begin
              w_cnt = r_cnt + CW'(1);
              if (w_hpt) w_clk = 1'b0;
            end
          end
          M_STEP: begin
            if (r_busy) begin
              if (w_wrap) begin
                w_cnt  = '0;
                w_busy = 1'b0;
                w_clk  = 1'b0;
              end else begin
                w_cnt = r_cnt + CW'(1);
                if (w_hpt) w_clk = 1'b0;
              end
            end else if (step_req[i]) begin
              w_cnt  = '0;
              w_busy = 1'b1;
              w_clk  = 1'b1;
              w_tick = 1'b1;
            end
          end
          default: begin
            w_cnt  = '0;
            w_clk  = 1'b0;
            w_busy = 1'b0;
          end
        endcase
      end
      if (w_acc) begin
        w_pend  = 1'b1;
        w_sdiv  = w_sdiv_in;
        w_smode = w_smode_in;
      end
    end

    always_ff @(posedge in_clk) begin
      if (!rst_n) begin
        r_cnt   <= '0;
        r_div   <= CW'(DEFAULT_DIV);
        r_mode  <= M_RUN;
        r_clk   <= 1'b0;
        r_tick  <= 1'b0;
        r_busy  <= 1'b0;
        r_pend  <= 1'b0;
        r_sdiv  <= CW'(DEFAULT_DIV);
        r_smode <= M_RUN;
      end else begin
        r_cnt   <= w_cnt;
        r_div   <= w_div;
        r_mode  <= w_mode;
        r_clk   <= w_clk;
        r_tick  <= w_tick;
        r_busy  <= w_busy;
        r_pend  <= w_pend;
        r_sdiv  <= w_sdiv;
        r_smode <= w_smode;
      end
    end

    assign out_clk[i]   = r_clk;
    assign out_tick[i]  = r_tick;
    assign step_busy[i] = r_busy;
    assign w_pend_v[i]  = r_pend;
  end
endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: RUN timing, reprogramming,
// clamp, STEP, OFF and mid-operation reset.
module tb_clk_div_multi;
  logic       in_clk;
  logic       rst_n;
  logic [1:0] step_req;
  logic [1:0] out_clk;
  logic [1:0] out_tick;
  logic [1:0] step_busy;
  int         cyc;
  int         checks;
  int         failures;

  clk_div_multi_if #(.CH(2), .CW(16)) cfg_if ();

  clk_div_multi #(
    .CH(2),
    .CW(16),
    .DEFAULT_DIV(20)
  ) dut (
    .in_clk   (in_clk),
    .rst_n    (rst_n),
    .cfg      (cfg_if),
    .step_req (step_req),
    .out_clk  (out_clk),
    .out_tick (out_tick),
    .step_busy(step_busy)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  task automatic step();
    @(posedge in_clk);
    #1;
    cyc++;
  endtask

  task automatic go_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s @cyc%0d observed=%0h expected=%0h",
             tag, cyc, obs, exp);
    end
  endtask

  task automatic cfg_drive(input logic ch,
                           input logic [15:0] div,
                           input logic [1:0] mode);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = ch;
    cfg_if.cfg_div   = div;
    cfg_if.cfg_mode  = mode;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    step_req = 2'b00;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = 1'b0;
    cfg_if.cfg_div   = 16'd0;
    cfg_if.cfg_mode  = 2'b00;
    repeat (2) begin
      @(posedge in_clk);
      #1;
    end
    chk("rst_clk", 32'(out_clk), 32'h0);
    chk("rst_tick", 32'(out_tick), 32'h0);
    chk("rst_busy", 32'(step_busy), 32'h0);
    chk("rst_ready", 32'(cfg_if.cfg_ready), 32'h1);
    rst_n = 1'b1;
    cyc   = 0;

    // Default RUN, div 20: first rise on 20th posedge
    go_to(19);
    chk("run_pre", 32'(out_clk), 32'h0);
    go_to(20);
    chk("run_rise20", 32'(out_clk), 32'h3);
    chk("run_tick20", 32'(out_tick), 32'h3);
    go_to(21);
    chk("run_tick_1cyc", 32'(out_tick), 32'h0);

    // Reprogram ch1 to div 6, accepted at posedge 25
    go_to(24);
    cfg_drive(1'b1, 16'd6, 2'b01);
    chk("cfg_ready_idle", 32'(cfg_if.cfg_ready), 32'h1);
    go_to(25);
    cfg_if.cfg_valid = 1'b0;
    chk("cfg_ready_pend", 32'(cfg_if.cfg_ready), 32'h0);
    go_to(29);
    chk("run_high29", 32'(out_clk[0]), 32'h1);
    go_to(30);
    chk("run_low30", 32'(out_clk[0]), 32'h0);
    go_to(39);
    chk("cfg_ready_39", 32'(cfg_if.cfg_ready), 32'h0);
    go_to(40);
    chk("rise40", 32'(out_clk), 32'h3);
    chk("tick40", 32'(out_tick), 32'h3);
    chk("cfg_ready_40", 32'(cfg_if.cfg_ready), 32'h1);
    go_to(42);
    chk("d6_high42", 32'(out_clk[1]), 32'h1);
    go_to(43);
    chk("d6_low43", 32'(out_clk[1]), 32'h0);
    go_to(45);
    chk("d6_low45", 32'(out_clk[1]), 32'h0);
    go_to(46);
    chk("d6_rise46", 32'(out_clk[1]), 32'h1);
    chk("d6_tick46", 32'(out_tick[1]), 32'h1);

    // Odd divisor 3: 1 high / 2 low
    cfg_drive(1'b1, 16'd3, 2'b01);
    go_to(47);
    cfg_if.cfg_valid = 1'b0;
    go_to(52);
    chk("d3_rise52", 32'(out_clk[1]), 32'h1);
    go_to(53);
    chk("d3_low53", 32'(out_clk[1]), 32'h0);
    go_to(54);
    chk("d3_low54", 32'(out_clk[1]), 32'h0);
    go_to(55);
    chk("d3_rise55", 32'(out_clk[1]), 32'h1);

    // div 0 clamps to 2
    cfg_drive(1'b1, 16'd0, 2'b01);
    go_to(56);
    cfg_if.cfg_valid = 1'b0;
    go_to(58);
    chk("d0_rise58", 32'(out_clk[1]), 32'h1);
    go_to(59);
    chk("d0_low59", 32'(out_clk[1]), 32'h0);
    go_to(60);
    chk("d0_rise60", 32'(out_clk[1]), 32'h1);
    chk("ch0_rise60", 32'(out_clk[0]), 32'h1);
    chk("ch0_tick60", 32'(out_tick[0]), 32'h1);

    // div 1 clamps to 2
    cfg_drive(1'b1, 16'd1, 2'b01);
    go_to(61);
    cfg_if.cfg_valid = 1'b0;
    go_to(62);
    chk("d1_rise62", 32'(out_clk[1]), 32'h1);
    go_to(63);
    chk("d1_low63", 32'(out_clk[1]), 32'h0);
    go_to(64);
    chk("d1_rise64", 32'(out_clk[1]), 32'h1);
    chk("d1_tick64", 32'(out_tick[1]), 32'h1);

    // ch0 to STEP div 4, applies at its wrap at 80
    cfg_drive(1'b0, 16'd4, 2'b10);
    go_to(65);
    cfg_if.cfg_valid = 1'b0;
    chk("step_pend", 32'(cfg_if.cfg_ready), 32'h0);
    go_to(79);
    chk("step_pend79", 32'(cfg_if.cfg_ready), 32'h0);
    go_to(80);
    chk("step_apply_clk", 32'(out_clk[0]), 32'h0);
    chk("step_apply_tick", 32'(out_tick[0]), 32'h0);
    chk("step_apply_rdy", 32'(cfg_if.cfg_ready), 32'h1);
    go_to(82);
    step_req = 2'b01;
    go_to(83);
    step_req = 2'b00;
    chk("step_go_clk", 32'(out_clk[0]), 32'h1);
    chk("step_go_tick", 32'(out_tick[0]), 32'h1);
    chk("step_go_busy", 32'(step_busy[0]), 32'h1);
    go_to(84);
    chk("step_84", {30'd0, out_clk[0], out_tick[0]}, 32'h2);
    step_req = 2'b01;
    go_to(85);
    step_req = 2'b00;
    chk("step_85_clk", 32'(out_clk[0]), 32'h0);
    chk("step_85_busy", 32'(step_busy[0]), 32'h1);
    go_to(86);
    chk("step_86_busy", 32'(step_busy[0]), 32'h1);
    go_to(87);
    chk("step_end_busy", 32'(step_busy[0]), 32'h0);
    chk("step_end_clk", 32'(out_clk[0]), 32'h0);
    chk("step_end_tick", 32'(out_tick[0]), 32'h0);
    go_to(88);
    chk("step_noqueue", 32'(step_busy[0]), 32'h0);
    chk("step_noqueue_clk", 32'(out_clk[0]), 32'h0);

    // ch1 RUN div 2 to OFF: finish the period, then stay low
    go_to(89);
    cfg_drive(1'b1, 16'd2, 2'b00);
    go_to(90);
    cfg_if.cfg_valid = 1'b0;
    chk("off_last_rise", 32'(out_clk[1]), 32'h1);
    go_to(91);
    chk("off_last_low", 32'(out_clk[1]), 32'h0);
    for (int k = 92; k <= 100; k++) begin
      go_to(k);
      chk("off_clk", 32'(out_clk[1]), 32'h0);
      chk("off_tick", 32'(out_tick[1]), 32'h0);
    end

    // OFF -> RUN div 10 applies next cycle
    cfg_drive(1'b1, 16'd10, 2'b01);
    go_to(101);
    cfg_if.cfg_valid = 1'b0;
    go_to(102);
    chk("off2run_clk", 32'(out_clk[1]), 32'h1);
    chk("off2run_tick", 32'(out_tick[1]), 32'h1);
    go_to(103);
    cfg_drive(1'b1, 16'd6, 2'b01);
    go_to(104);
    cfg_if.cfg_valid = 1'b0;
    chk("mid_pend", 32'(cfg_if.cfg_ready), 32'h0);

    // Reset with a config pending
    go_to(105);
    rst_n = 1'b0;
    go_to(106);
    rst_n = 1'b1;
    chk("mid_rst_ready", 32'(cfg_if.cfg_ready), 32'h1);
    chk("mid_rst_clk", 32'(out_clk), 32'h0);
    chk("mid_rst_busy", 32'(step_busy), 32'h0);
    go_to(125);
    chk("mid_rst_pre", 32'(out_clk), 32'h0);
    go_to(126);
    chk("mid_rst_rise", 32'(out_clk), 32'h3);
    chk("mid_rst_tick", 32'(out_tick), 32'h3);
    go_to(130);
    chk("mid_rst_div20", 32'(out_clk), 32'h3);
    go_to(136);
    chk("mid_rst_low", 32'(out_clk), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
